// File: rtl/psc_trigger_sched.sv
// rtl/psc_trigger_sched.sv - round-robin scheduler of trigger sources onto the PSC trigger transmitter
module psc_trigger_sched #(
    parameter int NUM_SRC     = 4,
    parameter int SRC_W       = 2,
    parameter int HOLDOFF     = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] trig_in,
    input  logic [NUM_SRC-1:0] enable_mask,
    input  logic               err_clr,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic [SRC_W-1:0]   tx_src,
    output logic [NUM_SRC-1:0] pending,
    output logic               sched_busy,
    output logic [15:0]        drop_cnt,
    output logic               err_timeout
);

    localparam int TMR_MAX = (HOLDOFF > ACK_TIMEOUT) ? HOLDOFF : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] hist;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt_vec;
    logic [NUM_SRC-1:0] drop_vec;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   gnt_idx;
    logic               found;
    logic [3:0]         drop_num;
    logic [16:0]        drop_sum;
    logic [TMR_W-1:0]   timer;

    // Round-robin search starts one past the last granted source.
    always_comb begin
        rise    = sync2 & ~hist;
        req     = pending & enable_mask;
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(ptr) + k) % NUM_SRC);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vec = '0;
        if (state == S_IDLE && found) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
        // A rise on a source being granted this cycle re-arms it rather than dropping.
        drop_vec = rise & enable_mask & pending & ~gnt_vec;
        drop_num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_num = drop_num + 4'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_cnt} + 17'(drop_num);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            hist     <= '0;
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            sync1    <= trig_in;
            sync2    <= sync1;
            hist     <= sync2;
            pending  <= ((pending & ~gnt_vec) | (rise & enable_mask)) & enable_mask;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ptr         <= SRC_W'(NUM_SRC - 1);
            tx_src      <= '0;
            tx_start    <= 1'b0;
            sched_busy  <= 1'b0;
            err_timeout <= 1'b0;
            timer       <= '0;
        end else begin
            tx_start <= 1'b0;
            // A timeout set below overrides a clear in the same cycle.
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (found) begin
                        tx_src     <= gnt_idx;
                        ptr        <= gnt_idx;
                        tx_start   <= 1'b1;
                        sched_busy <= 1'b1;
                        timer      <= '0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    timer <= timer + TMR_W'(1);
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        timer       <= '0;
                        state       <= S_HOLD;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        timer <= '0;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (timer == TMR_W'(HOLDOFF - 1)) begin
                        sched_busy <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    sched_busy <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psc_trigger_sched.sv
// tb/tb_psc_trigger_sched.sv - directed self-checking bench for psc_trigger_sched
module tb_psc_trigger_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  trig_in;
    logic [3:0]  enable_mask;
    logic        err_clr;
    logic        tx_busy;
    logic        tx_start;
    logic [1:0]  tx_src;
    logic [3:0]  pending;
    logic        sched_busy;
    logic [15:0] drop_cnt;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_cycles = 0;
    int tx_mode = 1;
    int tx_ctr = 0;
    int starts[$];
    int srcs[$];

    psc_trigger_sched #(
        .NUM_SRC(4),
        .SRC_W(2),
        .HOLDOFF(16),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .trig_in(trig_in),
        .enable_mask(enable_mask),
        .err_clr(err_clr),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_src(tx_src),
        .pending(pending),
        .sched_busy(sched_busy),
        .drop_cnt(drop_cnt),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor plus transmitter model: mode 0 never acks, 1 acks then busy 20 cycles, 2 always busy.
    initial tx_busy = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_start) begin
            starts.push_back(cyc);
            srcs.push_back(int'(tx_src));
        end
        if (sched_busy) busy_cycles = busy_cycles + 1;
        if (!reset) begin
            tx_ctr  = 0;
            tx_busy = 1'b0;
        end else if (tx_mode == 0) begin
            tx_busy = 1'b0;
        end else if (tx_mode == 2) begin
            tx_busy = 1'b1;
        end else begin
            if (tx_start) tx_ctr = 22;
            else if (tx_ctr > 0) tx_ctr = tx_ctr - 1;
            tx_busy = (tx_ctr > 0 && tx_ctr <= 20);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] bits);
        trig_in = bits;
        step(2);
        trig_in = 4'h0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        trig_in = 4'h0;
        err_clr = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        starts.delete();
        srcs.delete();
        busy_cycles = 0;
    endtask

    initial begin
        int rr_exp[4];
        rr_exp = '{1, 2, 3, 0};
        reset       = 1'b0;
        trig_in     = 4'h0;
        enable_mask = 4'hF;
        err_clr     = 1'b0;
        step(3);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_src", 32'(tx_src), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_sched_busy", 32'(sched_busy), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        reset = 1'b1;
        step(2);

        // Single trigger: pending after edge 3, start after edge 4, busy 1+2+20+16 cycles.
        busy_cycles = 0;
        starts.delete();
        srcs.delete();
        pulse(4'h1);
        step(1);
        check("single_pending", 32'(pending), 32'h1);
        step(1);
        check("single_tx_start", 32'(tx_start), 1);
        check("single_tx_src", 32'(tx_src), 0);
        check("single_pending_clr", 32'(pending), 0);
        step(60);
        check("single_busy_len", 32'(busy_cycles), 39);
        check("single_pending_end", 32'(pending), 0);
        check("single_drop", 32'(drop_cnt), 0);
        check("single_nframes", 32'(starts.size()), 1);

        // Round-robin over simultaneous requests, then a late source 0 request.
        starts.delete();
        srcs.delete();
        pulse(4'hE);
        step(10);
        pulse(4'h1);
        step(170);
        check("rr_nframes", 32'(starts.size()), 4);
        for (int i = 0; i < 4 && i < starts.size(); i++) begin
            check($sformatf("rr_src%0d", i), 32'(srcs[i]), 32'(rr_exp[i]));
            if (i > 0) check($sformatf("rr_gap%0d", i), 32'(starts[i] - starts[i-1]), 40);
        end

        // Second rise on source 2 while still pending is a single drop.
        do_reset();
        pulse(4'h1);
        pulse(4'h4);
        step(2);
        pulse(4'h4);
        step(100);
        check("drop_cnt_one", 32'(drop_cnt), 1);
        check("drop_nframes", 32'(starts.size()), 2);
        if (starts.size() == 2) check("drop_src2", 32'(srcs[1]), 2);

        // Handshake timeout, then clear, then clear racing a new timeout.
        do_reset();
        tx_mode = 0;
        pulse(4'h2);
        step(2);
        check("to_tx_start", 32'(tx_start), 1);
        step(63);
        check("to_err_before", 32'(err_timeout), 0);
        step(1);
        check("to_err_set", 32'(err_timeout), 1);
        check("to_in_hold", 32'(sched_busy), 1);
        step(15);
        check("to_hold_last", 32'(sched_busy), 1);
        step(1);
        check("to_idle", 32'(sched_busy), 0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("to_err_clr", 32'(err_timeout), 0);
        pulse(4'h2);
        step(65);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("to_set_wins", 32'(err_timeout), 1);
        step(20);

        // Masking: disabled source ignored; clearing a mask bit discards its pending request.
        do_reset();
        tx_mode = 1;
        enable_mask = 4'hE;
        pulse(4'h1);
        step(4);
        check("mask_no_pending", 32'(pending), 0);
        check("mask_no_drop", 32'(drop_cnt), 0);
        check("mask_no_frame", 32'(starts.size()), 0);
        pulse(4'h2);
        step(4);
        pulse(4'h8);
        step(1);
        check("mask_pend3", 32'(pending), 32'h8);
        enable_mask = 4'h6;
        step(1);
        check("mask_pend3_clr", 32'(pending), 0);
        step(60);
        check("mask_nframes", 32'(starts.size()), 1);
        check("mask_drop_end", 32'(drop_cnt), 0);

        // Reset during WAIT_DONE with sources 1 and 2 pending.
        do_reset();
        enable_mask = 4'hF;
        pulse(4'h1);
        step(2);
        pulse(4'h6);
        step(10);
        check("rstmid_pending_pre", 32'(pending), 32'h6);
        check("rstmid_busy_pre", 32'(sched_busy), 1);
        reset = 1'b0;
        #1;
        check("rstmid_tx_start", 32'(tx_start), 0);
        check("rstmid_tx_src", 32'(tx_src), 0);
        check("rstmid_pending", 32'(pending), 0);
        check("rstmid_sched_busy", 32'(sched_busy), 0);
        check("rstmid_drop_cnt", 32'(drop_cnt), 0);
        check("rstmid_err", 32'(err_timeout), 0);
        step(2);
        reset = 1'b1;
        pulse(4'h3);
        step(2);
        check("rstmid_first_start", 32'(tx_start), 1);
        check("rstmid_first_src", 32'(tx_src), 0);
        step(90);

        // Simultaneous drops, then sustained flooding to saturation.
        do_reset();
        tx_mode = 2;
        pulse(4'hF);
        step(2);
        pulse(4'hF);
        step(4);
        check("drop_multi", 32'(drop_cnt), 3);
        check("drop_multi_pending", 32'(pending), 32'hF);
        for (int i = 0; i < 33000; i++) begin
            trig_in = (i % 2 == 0) ? 4'hF : 4'h0;
            step(1);
        end
        trig_in = 4'h0;
        step(4);
        check("drop_saturated", 32'(drop_cnt), 32'hFFFF);
        pulse(4'hF);
        step(4);
        check("drop_stays_sat", 32'(drop_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psc_trigger_sched.md
Name: psc_trigger_sched

Overview:
- Schedules trigger requests from several asynchronous sources (EVR event output, software strobe, test pulses) onto the single PSC trigger serial transmitter, which accepts one frame at a time.
- Synchronises and edge-detects each source and latches one pending flag per source.
- Grants pending sources round-robin and drives the transmitter through a start/busy handshake.
- Enforces a minimum holdoff gap between frames and reports dropped triggers and handshake timeouts.

Parameters:
- NUM_SRC, 4: number of trigger sources (2..8).
- SRC_W, 2: width of the source index; must equal ceil(log2(NUM_SRC)).
- HOLDOFF, 16: idle cycles enforced after each frame completes (at least 1).
- ACK_TIMEOUT, 64: cycles allowed for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- trig_in  in  NUM_SRC  asynchronous trigger inputs; one trigger per rising edge.
- enable_mask  in  NUM_SRC  per-source enable, quasi-static.
- err_clr  in  1  single-cycle pulse; clears err_timeout.
- tx_busy  in  1  transmitter busy, high while a frame is being sent.
- tx_start  out  1  single-cycle start pulse to the transmitter.
- tx_src  out  SRC_W  index of the granted source; stable from tx_start until the next grant.
- pending  out  NUM_SRC  latched, not-yet-served triggers.
- sched_busy  out  1  high in every state except IDLE.
- drop_cnt  out  16  saturating count of dropped triggers.
- err_timeout  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset (reset low, asynchronous): every flop clears, including the sync chains. Output reset values: tx_start=0, tx_src=0, pending=0, sched_busy=0, drop_cnt=0, err_timeout=0. Round-robin pointer resets to NUM_SRC-1, so source 0 has first priority. Reset mid-frame returns to IDLE and discards all pending triggers.
- Input conditioning: per source, 2-flop synchroniser plus one history flop. rise = sync2 & ~hist.
- Pending set rules:
  - pending[i] sets on rise & enable_mask[i].
  - If pending[i] is already set, the rise is a drop: drop_cnt increments, saturating at 0xFFFF.
  - Simultaneous rises on different sources each latch independently.
  - Simultaneous drops on several sources in one cycle add their count to drop_cnt (saturating).
  - A rise in the same cycle the source's pending is cleared by a grant re-sets pending and is not a drop.
  - Clearing enable_mask[i] clears pending[i] on the next edge with no drop count.
- Latency: trig_in high before edge 1 gives pending after edge 3 and tx_start high for exactly the cycle after edge 4.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, HOLD.
  - IDLE: if any pending & enable_mask bit is set, select the first set index searching from pointer+1 with wrap. Register tx_src and pointer, clear that pending bit, go to START.
  - START: tx_start=1 for one cycle, then go to WAIT_ACK.
  - WAIT_ACK: on tx_busy=1 go to WAIT_DONE. After ACK_TIMEOUT cycles without tx_busy, set err_timeout and go to HOLD.
  - WAIT_DONE: on tx_busy=0 go to HOLD. There is no timeout; the transmitter bounds the frame length.
  - HOLD: count HOLDOFF cycles, then go to IDLE. Triggers continue to latch during HOLD.
- err_timeout: cleared by err_clr. If err_clr arrives in the same cycle as a new timeout, the set wins.
- tx_busy high while the FSM is in IDLE or START is ignored.

Test Plan:
- Single trigger: pulse trig_in[0] 40 ns wide (2 cycles), mask=0xF, transmitter acks 1 cycle after start and is busy 20 cycles -> tx_start after edge 4 with tx_src=0; sched_busy for 1+2+20+16 cycles; pending=0 at the end; drop_cnt=0.
- Round-robin: sources 1, 2 and 3 rise in the same cycle -> grants in order 1, 2, 3, then a new source 0 request is granted next. Consecutive tx_start pulses are at least 16 cycles apart after busy falls.
- Drop: source 2 rises twice while its first request is still pending -> drop_cnt=1, exactly one frame sent for source 2. Sustained flooding saturates drop_cnt at 0xFFFF.
- Timeout: tx_busy held at 0 -> err_timeout=1 exactly 64 cycles after tx_start, FSM passes through HOLD to IDLE. err_clr clears the flag; a simultaneous new timeout keeps it set.
- Masking: mask=0xE with trig_in[0] rising -> no pending bit and no drop. Clearing mask bit 3 while pending[3] is set -> pending[3]=0 next cycle and no frame for source 3.
- Reset mid-frame: assert reset during WAIT_DONE with pending=0x6 -> all outputs return to their reset values immediately. After release, a source 0 trigger is granted first.
